sipo_fifo_buf: RTL and testbench



---
 rtl/sipo_buf_pkg.sv | 18 +
 rtl/sipo_shift_reg.sv | 47 ++++
 rtl/sipo_fifo_buf.sv | 156 +++++++++++++++
 tb/tb_sipo_fifo_buf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_buf_pkg.sv
// Shared opcodes, FSM state encoding and sizing helper for the SIPO word buffer.
package sipo_buf_pkg;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WCOMMIT = 2'd2,
        RCOMMIT = 2'd3
    } state_e;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-to-parallel shift register with a word-length bit counter.
// `word` is the value including the bit sampled on the current edge, so the FIFO can store it on that same edge.
module sipo_shift_reg #(
    parameter int WORD_W    = 32,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    input  logic              en,
    output logic [WORD_W-1:0] word,
    output logic              done
);

    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic [BW-1:0]     cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        if (en) begin
            if (LSB_FIRST != 0) begin
                sr_d = {sin, sr_q[WORD_W-1:1]};
            end else begin
                sr_d = {sr_q[WORD_W-2:0], sin};
            end
            done  = (cnt_q == LAST);
            cnt_d = done ? '0 : cnt_q + 1'b1;
        end
        word = sr_d;
    end

    // Data bits need no reset: a full word is always shifted in before use.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_fifo_buf.sv
// Serial-in / parallel-out word FIFO with a request/ack/commit handshake,
// full/empty/count status and an error flag for rejected operations.
module sipo_fifo_buf
    import sipo_buf_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int DEPTH     = 64,
    parameter int LSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sin,
    input  logic                      val_op,
    input  logic                      op,
    output logic                      op_ack,
    output logic                      op_commit,
    output logic                      op_err,
    output logic [WORD_W-1:0]         pout,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rej_q, rej_d;
    logic              op_ack_q, op_ack_d;
    logic              op_commit_q, op_commit_d;
    logic              op_err_q, op_err_d;
    logic [WORD_W-1:0] pout_q, pout_d;
    logic              full_q, empty_q;

    logic              shift_en, shift_done, mem_we;
    logic [WORD_W-1:0] shift_word;

    sipo_shift_reg #(
        .WORD_W    (WORD_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .sin   (sin),
        .en    (shift_en),
        .word  (shift_word),
        .done  (shift_done)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rej_d       = rej_q;
        pout_d      = pout_q;
        op_ack_d    = 1'b0;
        op_commit_d = 1'b0;
        op_err_d    = 1'b0;
        shift_en    = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (val_op) begin
                    op_ack_d = 1'b1;
                    // Anything other than a clean read opcode (including X) is a write.
                    if (op == OP_RD) begin
                        rej_d    = empty_q;
                        op_err_d = empty_q;
                        state_d  = RCOMMIT;
                    end else begin
                        rej_d    = full_q;
                        op_err_d = full_q;
                        state_d  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (shift_done) begin
                    op_commit_d = 1'b1;
                    op_err_d    = rej_q;
                    state_d     = WCOMMIT;
                    if (!rej_q) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end
            end
            WCOMMIT: begin
                state_d = IDLE;
            end
            RCOMMIT: begin
                op_commit_d = 1'b1;
                op_err_d    = rej_q;
                state_d     = IDLE;
                if (!rej_q) begin
                    pout_d   = mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= shift_word;
        end
    end

    // Status flags are registered from the next count so they track `count` exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rej_q       <= 1'b0;
            op_ack_q    <= 1'b0;
            op_commit_q <= 1'b0;
            op_err_q    <= 1'b0;
            pout_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rej_q       <= rej_d;
            op_ack_q    <= op_ack_d;
            op_commit_q <= op_commit_d;
            op_err_q    <= op_err_d;
            pout_q      <= pout_d;
            full_q      <= (count_d == CW'(DEPTH));
            empty_q     <= (count_d == '0);
        end
    end

    assign op_ack    = op_ack_q;
    assign op_commit = op_commit_q;
    assign op_err    = op_err_q;
    assign pout      = pout_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_sipo_fifo_buf.sv
// Bench for sipo_fifo_buf: directed scenarios plus random traffic on three instances
// (64-deep LSB-first, 4-deep LSB-first, 4-deep MSB-first) against a queue model.
module tb_sipo_fifo_buf;

    logic clk = 1'b0;
    logic reset;
    logic        sin[3], val_op[3], op[3];
    logic        op_ack[3], op_commit[3], op_err[3], full[3], empty[3];
    logic [31:0] pout[3];
    logic [6:0]  cnt0;
    logic [2:0]  cnt1, cnt2;
    logic [6:0]  cnt[3];

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$], q1[$], q2[$];
    logic [31:0] mp[3];

    always #5 clk = ~clk;

    always_comb begin
        cnt[0] = cnt0;
        cnt[1] = {4'b0, cnt1};
        cnt[2] = {4'b0, cnt2};
    end

    sipo_fifo_buf #(.WORD_W(32), .DEPTH(64), .LSB_FIRST(1)) u0 (
        .clk(clk), .reset(reset), .sin(sin[0]), .val_op(val_op[0]), .op(op[0]),
        .op_ack(op_ack[0]), .op_commit(op_commit[0]), .op_err(op_err[0]),
        .pout(pout[0]), .count(cnt0), .full(full[0]), .empty(empty[0]));

    sipo_fifo_buf #(.WORD_W(32), .DEPTH(4), .LSB_FIRST(1)) u1 (
        .clk(clk), .reset(reset), .sin(sin[1]), .val_op(val_op[1]), .op(op[1]),
        .op_ack(op_ack[1]), .op_commit(op_commit[1]), .op_err(op_err[1]),
        .pout(pout[1]), .count(cnt1), .full(full[1]), .empty(empty[1]));

    sipo_fifo_buf #(.WORD_W(32), .DEPTH(4), .LSB_FIRST(0)) u2 (
        .clk(clk), .reset(reset), .sin(sin[2]), .val_op(val_op[2]), .op(op[2]),
        .op_ack(op_ack[2]), .op_commit(op_commit[2]), .op_err(op_err[2]),
        .pout(pout[2]), .count(cnt2), .full(full[2]), .empty(empty[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int mdepth(input int i);
        return (i == 0) ? 64 : 4;
    endfunction

    function automatic int msize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // MSB-first instance: serial bit b ends up at position 31-b.
    function automatic logic [31:0] arrive(input int i, input logic [31:0] w);
        logic [31:0] r;
        if (i != 2) return w;
        for (int b = 0; b < 32; b++) r[31-b] = w[b];
        return r;
    endfunction

    task automatic mpush(input int i, input logic [31:0] w);
        case (i)
            0:       q0.push_back(arrive(i, w));
            1:       q1.push_back(arrive(i, w));
            default: q2.push_back(arrive(i, w));
        endcase
    endtask

    task automatic mpop(input int i, output logic [31:0] w);
        case (i)
            0:       w = q0.pop_front();
            1:       w = q1.pop_front();
            default: w = q2.pop_front();
        endcase
    endtask

    task automatic mclear();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 3; k++) mp[k] = '0;
    endtask

    task automatic chk_status(input string tag, input int i);
        chk({tag, "_count"}, 32'(cnt[i]), 32'(msize(i)));
        chk({tag, "_full"},  32'(full[i]), 32'(msize(i) == mdepth(i)));
        chk({tag, "_empty"}, 32'(empty[i]), 32'(msize(i) == 0));
    endtask

    // abort_at > 0: assert reset just before serial bit abort_at is driven.
    task automatic do_write(input int i, input logic [31:0] w, input logic opv, input int abort_at);
        logic rej;
        int   seen;
        rej = (msize(i) == mdepth(i));
        @(negedge clk);
        val_op[i] = 1'b1;
        op[i]     = opv;
        @(posedge clk); #1;
        chk("wr_ack", 32'(op_ack[i]), 32'd1);
        chk("wr_ack_err", 32'(op_err[i]), 32'(rej));
        for (int b = 0; b < 32; b++) begin
            @(negedge clk);
            val_op[i] = 1'b0;
            op[i]     = 1'b0;
            if (abort_at > 0 && b == abort_at) begin
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                mclear();
                chk("abort_commit", 32'(op_commit[i]), 32'd0);
                chk_status("abort", i);
                @(negedge clk);
                reset = 1'b0;
                seen = 0;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (op_commit[i] !== 1'b0) seen++;
                end
                chk("abort_late_commit", 32'(seen), 32'd0);
                return;
            end
            sin[i] = w[b];
            @(posedge clk); #1;
            if (b == 0)  chk("wr_ack_pulse", 32'(op_ack[i]), 32'd0);
            if (b == 30) chk("wr_commit_early", 32'(op_commit[i]), 32'd0);
        end
        if (!rej) mpush(i, w);
        chk("wr_commit", 32'(op_commit[i]), 32'd1);
        chk("wr_commit_err", 32'(op_err[i]), 32'(rej));
        chk_status("wr", i);
        @(posedge clk); #1;
        chk("wr_commit_pulse", 32'(op_commit[i]), 32'd0);
    endtask

    task automatic do_read(input int i);
        logic rej;
        rej = (msize(i) == 0);
        @(negedge clk);
        val_op[i] = 1'b1;
        op[i]     = 1'b1;
        @(posedge clk); #1;
        chk("rd_ack", 32'(op_ack[i]), 32'd1);
        chk("rd_ack_err", 32'(op_err[i]), 32'(rej));
        chk("rd_commit_early", 32'(op_commit[i]), 32'd0);
        @(negedge clk);
        val_op[i] = 1'b0;
        op[i]     = 1'b0;
        @(posedge clk); #1;
        if (!rej) mpop(i, mp[i]);
        chk("rd_commit", 32'(op_commit[i]), 32'd1);
        chk("rd_commit_err", 32'(op_err[i]), 32'(rej));
        chk("rd_ack_pulse", 32'(op_ack[i]), 32'd0);
        chk("rd_pout", pout[i], mp[i]);
        chk_status("rd", i);
        @(posedge clk); #1;
        chk("rd_commit_pulse", 32'(op_commit[i]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sin[k] = 1'b0; val_op[k] = 1'b0; op[k] = 1'b0;
        end
        mclear();
        repeat (10) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", 32'(op_ack[k]), 32'd0);
            chk("rst_commit", 32'(op_commit[k]), 32'd0);
            chk("rst_err", 32'(op_err[k]), 32'd0);
            chk("rst_pout", pout[k], 32'd0);
            chk_status("rst", k);
        end
        @(negedge clk);
        reset = 1'b0;

        // Single write, then a four-word round trip in FIFO order.
        do_write(0, 32'h07020106, 1'b0, 0);
        chk("s1_count", 32'(cnt[0]), 32'd1);
        do_write(0, 32'h37323136, 1'b0, 0);
        do_write(0, 32'hDEADBEEF, 1'b0, 0);
        do_write(0, 32'h00001C30, 1'b0, 0);
        do_read(0);
        chk("s2_first", pout[0], 32'h07020106);
        do_read(0);
        do_read(0);
        do_read(0);
        chk("s2_last", pout[0], 32'h00001C30);

        // Read on empty is rejected and leaves pout alone.
        do_read(0);
        chk("s4_pout_hold", pout[0], 32'h00001C30);

        // Fill the 4-deep instance, overflow it, then wrap the pointers.
        for (int n = 0; n < 4; n++) do_write(1, $urandom, 1'b0, 0);
        chk("s3_full", 32'(full[1]), 32'd1);
        do_write(1, 32'hA5A5A5A5, 1'b0, 0);
        chk("s3_count_hold", 32'(cnt[1]), 32'd4);
        do_read(1);
        do_read(1);
        do_write(1, $urandom, 1'b0, 0);
        do_write(1, $urandom, 1'b0, 0);
        for (int n = 0; n < 4; n++) do_read(1);

        // MSB-first ordering.
        do_write(2, 32'hDEADBEEF, 1'b0, 0);
        do_read(2);
        chk("s6_msb_first", pout[2], 32'hF77DB57B);

        // An undefined opcode behaves as a write.
        do_write(0, 32'h13579BDF, 1'bx, 0);
        do_read(0);

        // Reset in the middle of a write.
        do_write(0, 32'h11111111, 1'b0, 0);
        do_write(0, 32'h22222222, 1'b0, 0);
        do_write(0, 32'h33333333, 1'b0, 10);
        chk("s5_empty", 32'(empty[0]), 32'd1);
        do_read(0);
        do_write(0, 32'hDEADBEEF, 1'b0, 0);
        do_read(0);
        chk("s5_readback", pout[0], 32'hDEADBEEF);

        // Random traffic on the two LSB-first instances.
        for (int n = 0; n < 60; n++) begin
            int ii;
            ii = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) do_write(ii, $urandom, 1'b0, 0);
            else                           do_read(ii);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
